// File: rtl/led_cube_uart_pkg.sv
// Shared definitions for the LED cube UART receive path.
// Holds the poller FSM state encoding, the UART register map, the status
// register bit positions and the sticky error record type.
package led_cube_uart_pkg;

  // Poller FSM state encoding
  typedef logic [2:0] state_t;
  localparam state_t S_GAP       = 3'd0;
  localparam state_t S_STAT_RD   = 3'd1;
  localparam state_t S_STAT_WAIT = 3'd2;
  localparam state_t S_DATA_RD   = 3'd3;
  localparam state_t S_DATA_WAIT = 3'd4;

  // UART register map
  localparam logic [4:0] UART_ADDR_RXDATA = 5'd0;
  localparam logic [4:0] UART_ADDR_STATUS = 5'd2;

  // UART status register bit positions
  localparam int ST_PE   = 0;
  localparam int ST_FE   = 1;
  localparam int ST_BRK  = 2;
  localparam int ST_ROE  = 3;
  localparam int ST_TOE  = 4;
  localparam int ST_TMT  = 5;
  localparam int ST_TRDY = 6;
  localparam int ST_RRDY = 7;

  // Sticky error record, packed in err_flags bit order
  typedef struct packed {
    logic timeout;
    logic roe;
    logic fe;
    logic pe;
  } err_t;

endpackage

// File: rtl/led_cube_byte_fifo.sv
// Show-ahead byte FIFO feeding the LED cube driver.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   push, din   : write strobe and byte (ignored when full)
//   pop         : consume head byte (ignored when empty)
//   dout, valid : head byte and non-empty flag
//   full, level : full flag and occupancy (0..DEPTH)
module led_cube_byte_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic          valid,
  output logic          full,
  output logic [LW-1:0] level
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (level == LW'(DEPTH));
  assign valid   = (level != '0);
  assign do_push = push && !full;
  assign do_pop  = pop && valid;
  // Zero when empty so the output is clean out of reset without clearing mem.
  assign dout    = valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

  // The poller never offers a byte when there is no room for it.
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/led_cube_uart_rx_poller.sv
// Avalon-MM master that polls the UART status register, reads rxdata when
// RRDY is set, and buffers received bytes for the LED cube driver.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   avm_*                : Avalon-MM read master to the UART slave
//   byte_data/valid/ready: show-ahead byte stream to the cube driver
//   fifo_level           : bytes currently buffered
//   err_flags            : sticky {timeout, ROE, FE, PE}
//   err_clear            : pulse to clear err_flags (wins over a same-cycle set)
module led_cube_uart_rx_poller
  import led_cube_uart_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 16,
  parameter int         POLL_GAP    = 8,
  parameter int         RSP_TIMEOUT = 255,
  parameter logic [4:0] ADDR_STATUS = UART_ADDR_STATUS,
  parameter logic [4:0] ADDR_RXDATA = UART_ADDR_RXDATA
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic [4:0]                  avm_address,
  output logic                        avm_read,
  input  logic [15:0]                 avm_readdata,
  input  logic                        avm_readdatavalid,
  input  logic                        avm_waitrequest,
  output logic [7:0]                  byte_data,
  output logic                        byte_valid,
  input  logic                        byte_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [3:0]                  err_flags,
  input  logic                        err_clear
);

  localparam int             LW       = $clog2(FIFO_DEPTH) + 1;
  localparam int             GW       = $clog2(POLL_GAP + 1);
  localparam logic [GW-1:0]  GAP_LOAD = GW'(POLL_GAP - 1);

  state_t        state, state_nxt;
  logic [GW-1:0] gap_cnt, gap_nxt;
  logic [7:0]    to_cnt;
  logic          to_hit;
  logic          push, full, fills;
  err_t          err, err_set;
  logic          unused_bits;

  // Only the status bits that feed err_flags and RRDY matter here.
  assign unused_bits = &{1'b0, avm_readdata[15:8], avm_readdata[ST_BRK], avm_readdata[ST_TOE],
                         avm_readdata[ST_TMT], avm_readdata[ST_TRDY]};

  assign avm_read    = (state == S_STAT_RD) || (state == S_DATA_RD);
  assign avm_address = (state == S_STAT_RD) ? ADDR_STATUS :
                       (state == S_DATA_RD) ? ADDR_RXDATA : 5'd0;
  assign to_hit      = (to_cnt == 8'(RSP_TIMEOUT));
  // The push about to land takes the last free slot: back off to GAP rather
  // than re-polling, so a later data read can never find the FIFO full.
  assign fills       = (fifo_level == LW'(FIFO_DEPTH - 1)) && !(byte_valid && byte_ready);
  assign err_flags   = err;

  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    push      = 1'b0;
    err_set   = '0;
    case (state)
      S_GAP: begin
        if (gap_cnt != '0)  gap_nxt   = gap_cnt - 1'b1;
        else if (!full)     state_nxt = S_STAT_RD;
      end
      S_STAT_RD: if (!avm_waitrequest) state_nxt = S_STAT_WAIT;
      S_STAT_WAIT: begin
        if (avm_readdatavalid) begin
          err_set.roe = avm_readdata[ST_ROE];
          err_set.fe  = avm_readdata[ST_FE];
          err_set.pe  = avm_readdata[ST_PE];
          if (avm_readdata[ST_RRDY]) begin
            state_nxt = S_DATA_RD;
          end else begin
            gap_nxt   = GAP_LOAD;
            state_nxt = S_GAP;
          end
        end else if (to_hit) begin
          err_set.timeout = 1'b1;
          gap_nxt         = GAP_LOAD;
          state_nxt       = S_GAP;
        end
      end
      S_DATA_RD: if (!avm_waitrequest) state_nxt = S_DATA_WAIT;
      S_DATA_WAIT: begin
        if (avm_readdatavalid) begin
          push = 1'b1;
          if (fills) begin
            gap_nxt   = '0;
            state_nxt = S_GAP;
          end else begin
            state_nxt = S_STAT_RD;
          end
        end else if (to_hit) begin
          err_set.timeout = 1'b1;
          gap_nxt         = GAP_LOAD;
          state_nxt       = S_GAP;
        end
      end
      default: state_nxt = S_GAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_GAP;
      gap_cnt <= '0;
      to_cnt  <= '0;
      err     <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_nxt;
      // Response timer only runs while waiting; it sits at 0 elsewhere, so
      // each *_WAIT state starts counting from 0.
      if ((state == S_STAT_WAIT) || (state == S_DATA_WAIT)) to_cnt <= to_cnt + 8'd1;
      else                                                  to_cnt <= '0;
      if (err_clear) err <= '0;
      else           err <= err | err_set;
    end
  end

  led_cube_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (avm_readdata[7:0]),
    .pop   (byte_ready),
    .dout  (byte_data),
    .valid (byte_valid),
    .full  (full),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_led_cube_uart_rx_poller.sv
// Bench for led_cube_uart_rx_poller: a behavioural UART slave and a byte
// consumer run inside one per-cycle step task; received bytes are queued
// as expected results when the slave returns them and compared on pop.
module tb_led_cube_uart_rx_poller;
  import led_cube_uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int GAP   = 8;
  localparam int TMO   = 255;

  logic        clk;
  logic        rst_n;
  logic [4:0]  avm_address;
  logic        avm_read;
  logic [15:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        avm_waitrequest;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic [4:0]  fifo_level;
  logic [3:0]  err_flags;
  logic        err_clear;

  led_cube_uart_rx_poller #(
    .FIFO_DEPTH(DEPTH), .POLL_GAP(GAP), .RSP_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .fifo_level(fifo_level), .err_flags(err_flags), .err_clear(err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          nchk, nerr;
  int          n_acc, n_data_acc, last_acc_cyc, rd_hold, wait_left;
  logic [4:0]  last_acc_addr;
  logic        pend, pend_is_data, mute_all, mute_data, stray, lat_pend;
  logic [15:0] pend_data, stat_once;
  logic [7:0]  lat_byte;
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock: slave + consumer act on the falling edge, then return 1 time
  // unit after the rising edge so the caller can drive inputs and sample.
  task automatic step();
    @(negedge clk);
    if (lat_pend) begin
      chk("push_lat", 32'({byte_valid, byte_data}), 32'({1'b1, lat_byte}));
      lat_pend = 1'b0;
    end
    if (byte_valid && byte_ready) begin
      if (exp_q.size() == 0) chk("sb_pending", 32'(exp_q.size()), 32'd1);
      else                   chk("sb_byte", 32'(byte_data), 32'(exp_q.pop_front()));
    end
    avm_readdatavalid = 1'b0;
    avm_readdata      = 16'h0000;
    if (pend) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = pend_data;
      pend              = 1'b0;
      if (pend_is_data) begin
        exp_q.push_back(pend_data[7:0]);
        if (!byte_valid) begin lat_pend = 1'b1; lat_byte = pend_data[7:0]; end
      end
    end else if (stray) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = 16'h0055;
      stray             = 1'b0;
    end
    if (avm_read && avm_address == UART_ADDR_RXDATA) rd_hold++;
    avm_waitrequest = 1'b0;
    if (avm_read === 1'b1) begin
      if (avm_address == UART_ADDR_RXDATA && wait_left > 0) begin
        avm_waitrequest = 1'b1;
        wait_left--;
      end else begin
        n_acc++;
        last_acc_cyc  = cyc;
        last_acc_addr = avm_address;
        if (avm_address == UART_ADDR_RXDATA) begin
          n_data_acc++;
          pend_data    = {8'h00, (rx_q.size() != 0) ? rx_q.pop_front() : 8'hEE};
          pend_is_data = 1'b1;
          pend         = !mute_all && !mute_data;
        end else begin
          pend_data    = ((rx_q.size() != 0) ? 16'h0080 : 16'h0000) | stat_once;
          stat_once    = 16'h0000;
          pend_is_data = 1'b0;
          pend         = !mute_all;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input string tag, input int budget);
    int start = n_acc;
    int t = 0;
    while (n_acc == start && t < budget) begin step(); t++; end
    chk(tag, 32'(n_acc), 32'(start + 1));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", nchk);
    $fatal(1, "watchdog");
  end

  initial begin
    int d, t0, nd0, na0, t;
    nchk = 0; nerr = 0; n_acc = 0; n_data_acc = 0; last_acc_cyc = 0; rd_hold = 0;
    wait_left = 0; last_acc_addr = '0; pend = 0; pend_is_data = 0; mute_all = 0;
    mute_data = 0; stray = 0; lat_pend = 0; pend_data = '0; stat_once = '0; lat_byte = '0;
    rst_n = 1'b0; byte_ready = 1'b1; err_clear = 1'b0;
    avm_readdata = '0; avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;

    // Reset values
    repeat (3) step();
    chk("rst_read", 32'(avm_read), 32'd0);
    chk("rst_addr", 32'(avm_address), 32'd0);
    chk("rst_valid", 32'(byte_valid), 32'd0);
    chk("rst_data", 32'(byte_data), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_err", 32'(err_flags), 32'd0);
    rst_n = 1'b1;
    step();
    chk("first_poll", 32'({avm_read, avm_address}), 32'({1'b1, UART_ADDR_STATUS}));

    // One byte, then immediate re-poll of status
    nd0 = n_data_acc;
    rx_q.push_back(8'h41);
    for (int i = 0; i < 6; i++) begin
      wait_acc("t1_acc", 40);
      if (last_acc_addr == UART_ADDR_RXDATA) break;
    end
    chk("t1_data_addr", 32'(last_acc_addr), 32'(UART_ADDR_RXDATA));
    d = last_acc_cyc;
    wait_acc("t1_next", 10);
    chk("t1_next_addr", 32'(last_acc_addr), 32'(UART_ADDR_STATUS));
    chk("t1_next_gap", 32'(last_acc_cyc - d), 32'd2);
    repeat (20) step();
    chk("t1_one_read", 32'(n_data_acc - nd0), 32'd1);
    chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("t1_level", 32'(fifo_level), 32'd0);

    // Idle polling spacing
    nd0 = n_data_acc;
    wait_acc("t2_acc0", 40);
    t0 = last_acc_cyc;
    for (int i = 0; i < 3; i++) begin
      wait_acc("t2_acc", 40);
      chk("t2_addr", 32'(last_acc_addr), 32'(UART_ADDR_STATUS));
      chk("t2_gap", 32'(last_acc_cyc - t0), 32'(GAP + 2));
      t0 = last_acc_cyc;
    end
    chk("t2_no_data", 32'(n_data_acc - nd0), 32'd0);

    // Waitrequest stall on a data read
    nd0 = n_data_acc;
    rd_hold = 0;
    wait_left = 5;
    rx_q.push_back(8'h5A);
    t = 0;
    while (n_data_acc == nd0 && t < 60) begin step(); t++; end
    chk("t3_hold", 32'(rd_hold), 32'd6);
    repeat (10) step();
    chk("t3_one_read", 32'(n_data_acc - nd0), 32'd1);
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Back-pressure: FIFO saturates, polling stops, drains in order
    byte_ready = 1'b0;
    for (int i = 0; i < 20; i++) rx_q.push_back(8'(i * 7 + 3));
    t = 0;
    while (fifo_level != 5'd16 && t < 800) begin step(); t++; end
    chk("t4_full", 32'(fifo_level), 32'd16);
    na0 = n_acc;
    repeat (40) step();
    chk("t4_no_reads", 32'(n_acc), 32'(na0));
    chk("t4_still_full", 32'(fifo_level), 32'd16);
    chk("t4_uart_left", 32'(rx_q.size()), 32'd4);
    byte_ready = 1'b1;
    t = 0;
    while ((exp_q.size() != 0 || rx_q.size() != 0 || fifo_level != 0) && t < 400) begin
      step(); t++;
    end
    chk("t4_uart_drained", 32'(rx_q.size()), 32'd0);
    chk("t4_sb_drained", 32'(exp_q.size()), 32'd0);
    chk("t4_level", 32'(fifo_level), 32'd0);

    // Status error bits, clear, then response timeout
    stat_once = 16'h000B;
    t = 0;
    while (err_flags == 4'd0 && t < 40) begin step(); t++; end
    chk("t5_err", 32'(err_flags), 32'b0111);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    chk("t5_clear", 32'(err_flags), 32'd0);
    mute_all = 1'b1;
    t = 0;
    while (err_flags[3] !== 1'b1 && t < 600) begin step(); t++; end
    chk("t5_to_flag", 32'(err_flags), 32'b1000);
    chk("t5_to_time", 32'(cyc - last_acc_cyc), 32'(TMO + 2));
    t0 = last_acc_cyc;
    wait_acc("t5_repoll", 300);
    chk("t5_repoll_gap", 32'(last_acc_cyc - t0), 32'(TMO + GAP + 2));
    mute_all = 1'b0;
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    chk("t5_clear2", 32'(err_flags), 32'd0);

    // Reset during DATA_WAIT, stray response afterwards
    repeat (300) step();
    mute_data = 1'b1;
    rx_q.push_back(8'h99);
    for (int i = 0; i < 6; i++) begin
      wait_acc("t6_acc", 40);
      if (last_acc_addr == UART_ADDR_RXDATA) break;
    end
    chk("t6_data_addr", 32'(last_acc_addr), 32'(UART_ADDR_RXDATA));
    rst_n = 1'b0;
    step();
    chk("t6_rst_read", 32'(avm_read), 32'd0);
    chk("t6_rst_level", 32'(fifo_level), 32'd0);
    rst_n = 1'b1;
    mute_data = 1'b0;
    stray = 1'b1;
    step();
    chk("t6_first_poll", 32'({avm_read, avm_address}), 32'({1'b1, UART_ADDR_STATUS}));
    repeat (30) step();
    chk("t6_no_push", 32'(fifo_level), 32'd0);
    chk("t6_no_valid", 32'(byte_valid), 32'd0);
    chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
